// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces KEY_NUM active-low push-buttons.
// Each key yields a clean active-high level plus one-cycle press/release
// strobes and, optionally, a one-cycle long-press strobe.
//
// Optional feature macro: KEY_LONG_PRESS_EN (long-press strobe on key_long).
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   pio_key      raw button pins, 0 = pressed (asynchronous, bouncy)
//   key_state    debounced level, 1 = pressed
//   key_press    one-cycle strobe on accepted press
//   key_release  one-cycle strobe on accepted release
//   key_long     one-cycle long-press strobe (constant 0 without the macro)
module key_debounce #(
  parameter int unsigned KEY_NUM         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] pio_key,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  // Terminal value: one past the strobe point, so the strobe fires once.
  localparam logic [HW-1:0] LONG_DONE = HW'(LONG_CYCLES);
`endif

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // Two-flop synchroniser, reset to the released (high) pin level.
  logic [KEY_NUM-1:0] meta;
  logic [KEY_NUM-1:0] stable;
  logic [KEY_NUM-1:0] sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta   <= '1;
      stable <= '1;
    end else begin
      meta   <= pio_key;
      stable <= meta;
    end
  end

  assign sync = ~stable;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    state_t        state;
    logic [CW-1:0] cnt;
    logic          level;
    logic          press;
    logic          release_s;

    // Per-key debounce FSM; strobes default low and pulse on acceptance.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state     <= IDLE;
        cnt       <= '0;
        level     <= 1'b0;
        press     <= 1'b0;
        release_s <= 1'b0;
      end else begin
        press     <= 1'b0;
        release_s <= 1'b0;
        case (state)
          IDLE: begin
            if (sync[i]) begin
              state <= PRESS_DB;
              cnt   <= CW'(1);
            end
          end
          PRESS_DB: begin
            if (!sync[i]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state <= PRESSED;
              cnt   <= '0;
              level <= 1'b1;
              press <= 1'b1;
            end else if (cnt != '1) begin
              cnt <= cnt + CW'(1);
            end
          end
          PRESSED: begin
            if (!sync[i]) begin
              state <= RELEASE_DB;
              cnt   <= CW'(1);
            end
          end
          RELEASE_DB: begin
            if (sync[i]) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              level     <= 1'b0;
              release_s <= 1'b1;
            end else if (cnt != '1) begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_state[i]   = level;
    assign key_press[i]   = press;
    assign key_release[i] = release_s;

`ifdef KEY_LONG_PRESS_EN
    logic [HW-1:0] hold;
    logic          long_s;

    // Hold counter: cleared while a press is being qualified (so it is zero
    // on entry to PRESSED), frozen during a release debounce so a rejected
    // release glitch keeps the accumulated hold time.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hold   <= '0;
        long_s <= 1'b0;
      end else begin
        long_s <= 1'b0;
        if (state == PRESS_DB) begin
          hold <= '0;
        end else if (state == PRESSED && sync[i]) begin
          if (hold == LONG_LAST) begin
            hold   <= LONG_DONE;
            long_s <= 1'b1;
          end else if (hold != LONG_DONE) begin
            hold <= hold + HW'(1);
          end
        end
      end
    end

    assign key_long[i] = long_s;
`endif
  end

`ifndef KEY_LONG_PRESS_EN
  assign key_long = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed self-checking bench for key_debounce with
// DEBOUNCE_CYCLES=8, LONG_CYCLES=32 and a 20 ns clock. Inputs change 1 ns
// after a rising edge; outputs are checked 1 ns after a rising edge.
module tb_key_debounce;

  localparam int unsigned KEY_NUM = 4;
  localparam int unsigned DB      = 8;
  localparam int unsigned LONG    = 32;
`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_EN = 1;
`else
  localparam int LONG_EN = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [KEY_NUM-1:0] pio_key;
  logic [KEY_NUM-1:0] key_state;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;

  int checks = 0;
  int errors = 0;

  // Strobe counters, sampled on the falling edge.
  int press_cnt   [KEY_NUM] = '{default: 0};
  int release_cnt [KEY_NUM] = '{default: 0};
  int long_cnt    [KEY_NUM] = '{default: 0};
  int both_cnt = 0;

  key_debounce #(
    .KEY_NUM         (KEY_NUM),
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pio_key     (pio_key),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < int'(KEY_NUM); i++) begin
      if (key_press[i] === 1'b1)   press_cnt[i]++;
      if (key_release[i] === 1'b1) release_cnt[i]++;
      if (key_long[i] === 1'b1)    long_cnt[i]++;
    end
    if ((key_press & key_release) != '0) both_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int sum(input int a [KEY_NUM]);
    int s = 0;
    for (int i = 0; i < int'(KEY_NUM); i++) s += a[i];
    return s;
  endfunction

  int snap_p1;
  int snap_rel;

  initial begin
    rst_n   = 1'b0;
    pio_key = 4'hF;

    // Reset held for 50 cycles, then 100 idle cycles.
    tick(50);
    check("rst_state",   int'(key_state),   0);
    check("rst_press",   int'(key_press),   0);
    check("rst_release", int'(key_release), 0);
    check("rst_long",    int'(key_long),    0);
    rst_n = 1'b1;
    tick(100);
    check("idle_state",  int'(key_state),  0);
    check("idle_strobes", sum(press_cnt) + sum(release_cnt) + sum(long_cnt), 0);

    // Clean press on key 0: sampled at edge N, accepted at N+9.
    pio_key[0] = 1'b0;
    tick(9);
    check("k0_pre_state", int'(key_state), 0);
    check("k0_pre_press", int'(key_press), 0);
    tick(1);
    check("k0_state", int'(key_state), 1);
    check("k0_press", int'(key_press), 1);
    tick(1);
    check("k0_press_off", int'(key_press), 0);
    check("k0_press_cnt", press_cnt[0], 1);

    // Long press: key_long one cycle, 32 cycles after key_press.
    tick(30);
    check("k0_long_early", int'(key_long), 0);
    tick(1);
    check("k0_long", int'(key_long), LONG_EN);
    tick(1);
    check("k0_long_off", int'(key_long), 0);
    check("k0_long_cnt", long_cnt[0], LONG_EN);

    // Bounce on key 1: runs of 3 samples, then settle low.
    snap_p1 = press_cnt[1];
    for (int i = 0; i < 40; i++) begin
      pio_key[1] = ((i / 3) % 2) != 0;
      tick(1);
    end
    check("k1_bounce_press", press_cnt[1] - snap_p1, 0);
    check("k1_bounce_state", int'(key_state), 1);
    pio_key[1] = 1'b0;
    tick(9);
    check("k1_pre_state", int'(key_state), 1);
    tick(1);
    check("k1_state", int'(key_state), 3);
    check("k1_press", int'(key_press), 2);
    tick(1);
    check("k1_press_off", int'(key_press), 0);
    check("k1_press_cnt", press_cnt[1] - snap_p1, 1);

    // Keys 3:2 pressed together, then released on the same edge.
    pio_key[3:2] = 2'b00;
    tick(20);
    check("k32_state", int'(key_state), 15);
    check("k32_press_cnt", press_cnt[2] + press_cnt[3], 2);
    pio_key[3:2] = 2'b11;
    tick(9);
    check("k32_pre_state", int'(key_state), 15);
    check("k32_pre_rel",   int'(key_release), 0);
    tick(1);
    check("k32_release", int'(key_release), 12);
    check("k32_rel_state", int'(key_state), 3);
    tick(1);
    check("k32_release_off", int'(key_release), 0);

    // Reset while key 2 is debouncing (counter = 5); keys 0,1 still held.
    snap_rel = sum(release_cnt);
    pio_key[2] = 1'b0;
    tick(7);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_state", int'(key_state), 0);
    check("mid_rst_press", int'(key_press), 0);
    check("mid_rst_rel",   int'(key_release), 0);
    rst_n = 1'b1;
    tick(9);
    check("post_rst_pre_state", int'(key_state), 0);
    check("post_rst_pre_press", int'(key_press), 0);
    tick(1);
    check("post_rst_state", int'(key_state), 7);
    check("post_rst_press", int'(key_press), 7);
    tick(1);
    check("post_rst_press_off", int'(key_press), 0);
    check("post_rst_no_release", sum(release_cnt) - snap_rel, 0);
    check("press_release_excl", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side counterpart to the board LED driver: reads KEY_NUM active-low push-buttons (pio_key) from the board pins.
- Per key: synchronise, debounce, and output a clean level plus one-cycle press/release strobes.
- Sits between the pins and user logic (LED control, mode select); instantiated once per board top.

Parameters:
- KEY_NUM, 4: number of independent key inputs.
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a change (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 100000000: hold time for the long-press strobe (optional feature only); must exceed DEBOUNCE_CYCLES.
- Counter width is $clog2 of the largest count plus 1, per key.

Ports:
- clk  input  1  system clock; the single clock domain.
- rst_n  input  1  reset: one clock, synchronous, active-low.
- pio_key  input  KEY_NUM  raw button pins, 0 = pressed, asynchronous, bouncy.
- key_state  output  KEY_NUM  debounced level, 1 = pressed.
- key_press  output  KEY_NUM  one-cycle strobe on accepted press.
- key_release  output  KEY_NUM  one-cycle strobe on accepted release.
- key_long  output  KEY_NUM  one-cycle long-press strobe; tied 0 when the feature is off.

Behaviour:
- Everything (synchroniser included) is clocked on the clk rising edge; all state is cleared only while rst_n=0 at a clock edge.
- Reset values:
  - synchroniser flops 1 (released).
  - counters 0.
  - key_state, key_press, key_release, key_long all 0.
  - per-key FSM IDLE.
- Synchroniser: 2 flops per key, inverted after stage 2 to give an active-high sync[i]. A pin change sampled at edge N is visible on sync at edge N+1.
- Per-key FSM states:
  - IDLE (released, stable): sync=1 -> PRESS_DB, counter=1; else stay.
  - PRESS_DB:
    - sync=0 -> IDLE, counter=0 (glitch rejected, no strobes).
    - sync=1 and counter==DEBOUNCE_CYCLES-1 -> PRESSED, key_state<=1, key_press=1 for one cycle, counter=0.
    - otherwise counter+1.
  - PRESSED: sync=0 -> RELEASE_DB, counter=1. sync=1 -> stay (long-press counting only when the feature is on).
  - RELEASE_DB: mirror of PRESS_DB.
    - sync=1 -> PRESSED, no strobe.
    - on completion -> IDLE, key_state<=0, key_release=1 for one cycle.
- Latency: a clean pin edge sampled at edge N gives a key_state change and strobe registered at edge N+DEBOUNCE_CYCLES+1.
- Strobes and key_state are registered outputs, asserted in the same cycle as each other. key_press and key_release are never both high for one key.
- Keys are fully independent; simultaneous presses on several keys give simultaneous strobes.
- Bounce shorter than DEBOUNCE_CYCLES consecutive samples never changes key_state, at any bounce rate.
- Counter saturates; it never wraps.
- Reset mid-operation:
  - all outputs go to 0 at the reset edge and the FSM goes to IDLE.
  - a key held through reset is reported as a new press DEBOUNCE_CYCLES+1 cycles after the synchroniser refills. This is intended; no release strobe is emitted for it.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - In PRESSED, a separate hold counter counts cycles with sync=1.
  - When it reaches LONG_CYCLES-1, key_long pulses for one cycle and the counter holds (saturates). There is one strobe per press; there is no auto-repeat.
  - The hold counter clears on entry to PRESSED; it is frozen (not cleared) in RELEASE_DB, so a rejected release glitch does not restart the hold time.
- Not defined: hold counter logic is absent and key_long is constant 0.

Test Plan (DEBOUNCE_CYCLES=8, LONG_CYCLES=32, 20 ns clock):
- Reset: rst_n=0 for 50 cycles with pio_key=4'hF; release -> all outputs 0, no strobes for 100 cycles.
- Clean press: pio_key[0] 1->0 sampled at edge N -> key_state[0]=1 and key_press[0]=1 for exactly one cycle at edge N+9; other bits stay 0.
- Bounce: pio_key[1] toggles 0/1 every 3 cycles for 40 cycles, then holds 0 -> no strobe during toggling; single key_press[1] 9 cycles after final settle.
- Release, with simultaneous keys: pio_key[3:2] released on the same edge -> key_release[3:2] both pulse on the same cycle, 9 cycles later; key_state[3:2]=0.
- Reset mid-debounce: assert rst_n=0 at counter value 5 with key held; release -> no strobe until 8 samples plus sync delay after reset, then one key_press.
- KEY_LONG_PRESS_EN: hold key 0 for 100 cycles -> key_long[0] exactly one pulse, 32 cycles after key_press[0]. Without the macro, key_long stays 0.
